// File: rtl/nec_ir_pkg.sv
// Shared types, nominal NEC pulse widths and the microsecond-to-cycle conversion
// used by the NEC IR receiver.
`timescale 1ns/1ps
package nec_ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_LO,
    LEAD_HI,
    BIT_LO,
    BIT_HI,
    REP_LO,
    CHECK
  } state_t;

  localparam int unsigned LEAD_US   = 9000;
  localparam int unsigned SPACE_US  = 4500;
  localparam int unsigned REP_US    = 2250;
  localparam int unsigned BURST_US  = 560;
  localparam int unsigned ONE_US    = 1690;
  localparam int unsigned SAT_US    = 15000;
  localparam int unsigned BIT_CNT_W = 6;

  // Nominal width scaled by pct/100, truncated to whole clock cycles.
  function automatic int unsigned us_to_cycles(input int unsigned freq,
                                               input int unsigned us,
                                               input int unsigned pct);
    logic [63:0] prod;
    prod = 64'(freq) * 64'(us) * 64'(pct);
    return 32'(prod / 64'd100_000_000);
  endfunction

endpackage

// File: rtl/nec_pulse_meas.sv
// Synchronises the IR pin, detects edges and measures how long the line held
// its previous level; the width counter restarts on every edge and saturates.
`timescale 1ns/1ps
module nec_pulse_meas #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 20
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             remote_in,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] width
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   level;

  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

  // Reset to the idle-high level so releasing reset never fakes an edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync  <= '1;
      prev  <= 1'b1;
      width <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], remote_in};
      prev <= level;
      if (rise || fall)
        width <= '0;
      else if (width != '1)
        width <= width + 1'b1;
    end
  end

endmodule

// File: rtl/nec_ir_rx.sv
// NEC IR receiver: classifies measured pulse widths into leader, repeat and
// data phases, assembles the 32-bit frame, validates it and tracks the repeat window.
`timescale 1ns/1ps
module nec_ir_rx
  import nec_ir_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
  parameter int unsigned TOL_PCT        = 20,
  parameter bit          EXT_ADDR       = 1'b0,
  parameter bit          ADDR_FILTER_EN = 1'b0,
  parameter logic [15:0] ADDR_MATCH     = 16'h0000,
  parameter int unsigned REPEAT_WIN_MS  = 120,
  parameter int          SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        remote_in,
  output logic        data_en,
  output logic        repeat_en,
  output logic        err,
  output logic        busy,
  output logic [15:0] addr,
  output logic [7:0]  data
);

  localparam int unsigned LO        = 100 - TOL_PCT;
  localparam int unsigned HI        = 100 + TOL_PCT;
  localparam int unsigned LEAD_MIN  = us_to_cycles(CLK_FREQ_HZ, LEAD_US, LO);
  localparam int unsigned LEAD_MAX  = us_to_cycles(CLK_FREQ_HZ, LEAD_US, HI);
  localparam int unsigned SPACE_MIN = us_to_cycles(CLK_FREQ_HZ, SPACE_US, LO);
  localparam int unsigned SPACE_MAX = us_to_cycles(CLK_FREQ_HZ, SPACE_US, HI);
  localparam int unsigned REP_MIN   = us_to_cycles(CLK_FREQ_HZ, REP_US, LO);
  localparam int unsigned REP_MAX   = us_to_cycles(CLK_FREQ_HZ, REP_US, HI);
  localparam int unsigned BURST_MIN = us_to_cycles(CLK_FREQ_HZ, BURST_US, LO);
  localparam int unsigned BURST_MAX = us_to_cycles(CLK_FREQ_HZ, BURST_US, HI);
  localparam int unsigned ONE_MIN   = us_to_cycles(CLK_FREQ_HZ, ONE_US, LO);
  localparam int unsigned ONE_MAX   = us_to_cycles(CLK_FREQ_HZ, ONE_US, HI);
  localparam int unsigned SAT_CYC   = us_to_cycles(CLK_FREQ_HZ, SAT_US, 100);
  localparam int unsigned REP_CYC   = us_to_cycles(CLK_FREQ_HZ, REPEAT_WIN_MS * 1000, 100);
  localparam int          CNT_W     = $clog2(SAT_CYC + 1);
  localparam int          REP_W     = $clog2(REP_CYC + 1);

  function automatic logic in_win(input logic [31:0] v, input int unsigned lo,
                                  input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

  state_t               state, state_nxt;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [31:0]          shift, shift_nxt;
  logic                 data_en_nxt, repeat_en_nxt, err_nxt;
  logic                 rise, fall;
  logic [CNT_W-1:0]     width;
  logic [31:0]          w;
  logic [15:0]          addr_word;
  logic                 frame_ok;
  logic                 rep_open;
  logic [REP_W-1:0]     rep_cnt;

  nec_pulse_meas #(
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W)
  ) u_meas (
    .clk      (clk),
    .rstn     (rstn),
    .remote_in(remote_in),
    .rise     (rise),
    .fall     (fall),
    .width    (width)
  );

  assign w         = 32'(width);
  assign addr_word = EXT_ADDR ? shift[15:0] : {8'h00, shift[7:0]};
  assign frame_ok  = (shift[23:16] == ~shift[31:24]) &&
                     (EXT_ADDR || (shift[7:0] == ~shift[15:8]));
  assign busy      = (state != IDLE) && (state != LEAD_LO);

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shift_nxt     = shift;
    data_en_nxt   = 1'b0;
    repeat_en_nxt = 1'b0;
    err_nxt       = 1'b0;
    case (state)
      IDLE: if (fall) state_nxt = LEAD_LO;
      LEAD_LO: begin
        if (rise)
          state_nxt = in_win(w, LEAD_MIN, LEAD_MAX) ? LEAD_HI : IDLE;
        else if (w > LEAD_MAX)
          state_nxt = IDLE;
      end
      LEAD_HI: begin
        if (fall && in_win(w, SPACE_MIN, SPACE_MAX)) begin
          state_nxt   = BIT_LO;
          bit_cnt_nxt = '0;
        end else if (fall && in_win(w, REP_MIN, REP_MAX)) begin
          state_nxt = REP_LO;
        end else if (fall || w > SPACE_MAX) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end
      end
      BIT_LO: begin
        if (rise && in_win(w, BURST_MIN, BURST_MAX)) begin
          state_nxt = (bit_cnt == BIT_CNT_W'(32)) ? CHECK : BIT_HI;
        end else if (rise || w > BURST_MAX) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end
      end
      BIT_HI: begin
        // Bits arrive LSB first, so shift in from the top.
        if (fall && (in_win(w, BURST_MIN, BURST_MAX) || in_win(w, ONE_MIN, ONE_MAX))) begin
          shift_nxt   = {in_win(w, ONE_MIN, ONE_MAX), shift[31:1]};
          bit_cnt_nxt = bit_cnt + 1'b1;
          state_nxt   = BIT_LO;
        end else if (fall || w > ONE_MAX) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end
      end
      REP_LO: begin
        if (rise && in_win(w, BURST_MIN, BURST_MAX)) begin
          state_nxt     = IDLE;
          repeat_en_nxt = rep_open;
        end else if (rise || w > BURST_MAX) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end
      end
      CHECK: begin
        state_nxt = IDLE;
        if (!frame_ok)
          err_nxt = 1'b1;
        else if (!ADDR_FILTER_EN || addr_word == ADDR_MATCH)
          data_en_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      data_en   <= 1'b0;
      repeat_en <= 1'b0;
      err       <= 1'b0;
      addr      <= '0;
      data      <= '0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      data_en   <= data_en_nxt;
      repeat_en <= repeat_en_nxt;
      err       <= err_nxt;
      if (data_en_nxt) begin
        addr <= addr_word;
        data <= shift[23:16];
      end
    end
  end

  // Repeat window reopens on every accepted frame or repeat and lapses on its own.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rep_open <= 1'b0;
      rep_cnt  <= '0;
    end else if (data_en_nxt || repeat_en_nxt) begin
      rep_open <= 1'b1;
      rep_cnt  <= '0;
    end else if (rep_open) begin
      if (rep_cnt == REP_W'(REP_CYC - 1))
        rep_open <= 1'b0;
      else
        rep_cnt <= rep_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_nec_ir_rx.sv
// Directed bench for nec_ir_rx: three instances (standard, extended address,
// address filter) share one IR line clocked at 50 kHz so frames stay short.
`timescale 1us/1ns
module tb_nec_ir_rx;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic remote_in = 1'b1;

  logic [2:0] de, rep, er, bz;
  logic [15:0] ad [3];
  logic [7:0]  dt [3];

  int de_cnt [3];
  int rep_cnt [3];
  int err_cnt [3];
  int multi = 0;
  int checks = 0;
  int failures = 0;
  int s_de, s_rep, s_err;

  always #10 clk = ~clk;

  nec_ir_rx #(.CLK_FREQ_HZ(50_000)) dut0 (
    .clk(clk), .rstn(rstn), .remote_in(remote_in), .data_en(de[0]), .repeat_en(rep[0]),
    .err(er[0]), .busy(bz[0]), .addr(ad[0]), .data(dt[0]));

  nec_ir_rx #(.CLK_FREQ_HZ(50_000), .EXT_ADDR(1'b1)) dut1 (
    .clk(clk), .rstn(rstn), .remote_in(remote_in), .data_en(de[1]), .repeat_en(rep[1]),
    .err(er[1]), .busy(bz[1]), .addr(ad[1]), .data(dt[1]));

  nec_ir_rx #(.CLK_FREQ_HZ(50_000), .ADDR_FILTER_EN(1'b1), .ADDR_MATCH(16'h005A)) dut2 (
    .clk(clk), .rstn(rstn), .remote_in(remote_in), .data_en(de[2]), .repeat_en(rep[2]),
    .err(er[2]), .busy(bz[2]), .addr(ad[2]), .data(dt[2]));

  // Pulse counters sampled on the inactive edge.
  initial for (int i = 0; i < 3; i++) begin
    de_cnt[i] = 0; rep_cnt[i] = 0; err_cnt[i] = 0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (de[i])  de_cnt[i]  <= de_cnt[i] + 1;
      if (rep[i]) rep_cnt[i] <= rep_cnt[i] + 1;
      if (er[i])  err_cnt[i] <= err_cnt[i] + 1;
      if (int'(de[i]) + int'(rep[i]) + int'(er[i]) > 1) multi <= multi + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse(input int low_us, input int high_us);
    remote_in = 1'b0;
    #(low_us);
    remote_in = 1'b1;
    #(high_us);
  endtask

  // Sends one frame; pct scales every width, stretch_idx replaces one bit's space,
  // stop_at abandons the frame before that bit (-1 disables either).
  task automatic applyStimulus(input logic [7:0] a_lo, input logic [7:0] a_hi,
                               input logic [7:0] cmd, input logic [7:0] cmd_inv,
                               input int pct, input int stretch_idx,
                               input int stretch_us, input int stop_at);
    logic [31:0] word;
    word = {cmd_inv, cmd, a_hi, a_lo};
    pulse(9000 * pct / 100, 4500 * pct / 100);
    for (int i = 0; i < 32; i++) begin
      if (i == stop_at) return;
      if (i == stretch_idx)
        pulse(560 * pct / 100, stretch_us);
      else
        pulse(560 * pct / 100, (word[i] ? 1690 : 560) * pct / 100);
    end
    remote_in = 1'b0;
    #(560 * pct / 100);
    remote_in = 1'b1;
    #(2000);
  endtask

  task automatic sendRepeat();
    pulse(9000, 2250);
    remote_in = 1'b0;
    #(560);
    remote_in = 1'b1;
    #(2000);
  endtask

  task automatic snap(input int i);
    s_de = de_cnt[i]; s_rep = rep_cnt[i]; s_err = err_cnt[i];
  endtask

  initial begin
    #50.5;
    checkOutput("reset_busy", 32'(bz[0]), 0);
    checkOutput("reset_addr", 32'(ad[0]), 0);
    checkOutput("reset_data", 32'(dt[0]), 0);
    rstn = 1'b1;
    #200;

    $display("[TB] frame addr 5A cmd 45");
    snap(0);
    applyStimulus(8'h5A, 8'hA5, 8'h45, 8'hBA, 100, -1, 0, -1);
    checkOutput("t1_data_en", 32'(de_cnt[0] - s_de), 1);
    checkOutput("t1_addr", 32'(ad[0]), 32'h005A);
    checkOutput("t1_data", 32'(dt[0]), 32'h45);
    checkOutput("t1_err", 32'(err_cnt[0] - s_err), 0);

    $display("[TB] repeats inside and outside window");
    #38000;
    snap(0);
    sendRepeat();
    checkOutput("t2_repeat_open", 32'(rep_cnt[0] - s_rep), 1);
    checkOutput("t2_data_held", 32'(dt[0]), 32'h45);
    #200000;
    snap(0);
    sendRepeat();
    checkOutput("t2_repeat_closed", 32'(rep_cnt[0] - s_rep), 0);
    checkOutput("t2_err_closed", 32'(err_cnt[0] - s_err), 0);

    $display("[TB] corrupted cmd_inv");
    snap(0);
    applyStimulus(8'h5A, 8'hA5, 8'h45, 8'hBB, 100, -1, 0, -1);
    checkOutput("t3_err", 32'(err_cnt[0] - s_err), 1);
    checkOutput("t3_data_en", 32'(de_cnt[0] - s_de), 0);
    checkOutput("t3_data_held", 32'(dt[0]), 32'h45);

    $display("[TB] extended address");
    snap(1);
    applyStimulus(8'h12, 8'h34, 8'h07, 8'hF8, 100, -1, 0, -1);
    checkOutput("t4_data_en", 32'(de_cnt[1] - s_de), 1);
    checkOutput("t4_addr", 32'(ad[1]), 32'h3412);
    checkOutput("t4_data", 32'(dt[1]), 32'h07);

    $display("[TB] address filter");
    snap(2);
    applyStimulus(8'h33, 8'hCC, 8'h45, 8'hBA, 100, -1, 0, -1);
    checkOutput("t5_drop_data_en", 32'(de_cnt[2] - s_de), 0);
    checkOutput("t5_drop_err", 32'(err_cnt[2] - s_err), 0);
    snap(2);
    applyStimulus(8'h5A, 8'hA5, 8'h11, 8'hEE, 100, -1, 0, -1);
    checkOutput("t5_pass_data_en", 32'(de_cnt[2] - s_de), 1);
    checkOutput("t5_pass_data", 32'(dt[2]), 32'h11);

    $display("[TB] tolerance, stretched bit, mid-frame reset");
    snap(0);
    applyStimulus(8'hA5, 8'h5A, 8'h3C, 8'hC3, 115, -1, 0, -1);
    checkOutput("t6_slow_data_en", 32'(de_cnt[0] - s_de), 1);
    checkOutput("t6_slow_addr", 32'(ad[0]), 32'h00A5);
    checkOutput("t6_slow_data", 32'(dt[0]), 32'h3C);
    snap(0);
    applyStimulus(8'h5A, 8'hA5, 8'h45, 8'hBA, 100, 1, 2300, -1);
    checkOutput("t6_stretch_err", 32'(err_cnt[0] - s_err), 1);
    checkOutput("t6_stretch_data_en", 32'(de_cnt[0] - s_de), 0);
    checkOutput("t6_stretch_data", 32'(dt[0]), 32'h3C);
    applyStimulus(8'h5A, 8'hA5, 8'h45, 8'hBA, 100, -1, 0, 10);
    checkOutput("t6_busy_mid", 32'(bz[0]), 1);
    rstn = 1'b0;
    #100;
    checkOutput("t6_rst_busy", 32'(bz[0]), 0);
    checkOutput("t6_rst_addr", 32'(ad[0]), 0);
    checkOutput("t6_rst_data", 32'(dt[0]), 0);
    rstn = 1'b1;
    #1000;
    snap(0);
    applyStimulus(8'h5A, 8'hA5, 8'h81, 8'h7E, 100, -1, 0, -1);
    checkOutput("t6_after_data_en", 32'(de_cnt[0] - s_de), 1);
    checkOutput("t6_after_data", 32'(dt[0]), 32'h81);
    checkOutput("t6_after_addr", 32'(ad[0]), 32'h005A);
    checkOutput("t6_after_err", 32'(err_cnt[0] - s_err), 0);

    checkOutput("single_pulse_per_cycle", 32'(multi), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
